// File: rtl/aes_round_controller_pkg.sv
// Shared AES types and key-size round counts.
// Used by the round sequencer and the key-expansion sequencer.
package AESDefinitions;

  typedef logic [3:0][3:0][7:0] state_t;
  typedef logic [3:0]           round_index_t;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

endpackage

// File: rtl/round_step_counter.sv
// Loadable up-counter with a terminal flag at count == limit.
// Clear has priority over enable.
module round_step_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         done
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;
  assign done  = (count_q == limit);

endmodule

// File: rtl/aes_round_controller.sv
// Iterative sequencer for a shared single-round AES datapath.
// Holds the working block and steps rounds 0..NUM_ROUNDS.
module aes_round_controller
  import AESDefinitions::*;
#(
  parameter int NUM_ROUNDS = NR_128
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_decrypt,
  input  state_t       in_state,
  output logic         rnd_valid,
  output state_t       rnd_state,
  output round_index_t rnd_index,
  output logic         rnd_initial,
  output logic         rnd_final,
  output logic         rnd_decrypt,
  input  state_t       rnd_result,
  output logic         out_valid,
  input  logic         out_ready,
  output state_t       out_state
);

  localparam round_index_t NR = round_index_t'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    ROUND = 3'b010,
    DONE  = 3'b100
  } fsm_t;

  fsm_t         st_q;
  fsm_t         st_d;
  state_t       state_q;
  logic         dir_q;
  logic         load;
  logic         last;
  round_index_t step;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q <= IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d      = st_q;
    in_ready  = 1'b0;
    rnd_valid = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    unique case (1'b1)
      st_q[0]: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load = 1'b1;
          st_d = ROUND;
        end
      end
      st_q[1]: begin
        rnd_valid = 1'b1;
        if (last) st_d = DONE;
      end
      st_q[2]: begin
        out_valid = 1'b1;
        if (out_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= '0;
      dir_q   <= 1'b0;
    end else if (load) begin
      state_q <= in_state;
      dir_q   <= in_decrypt;
    end else if (rnd_valid) begin
      state_q <= rnd_result;
    end
  end

  // Step is held at zero while idle so the next block starts clean.
  round_step_counter #(
    .W(4)
  ) u_step (
    .clk    (clock),
    .rst_n  (reset_n),
    .clear  (in_ready),
    .enable (rnd_valid & ~last),
    .limit  (NR),
    .count  (step),
    .done   (last)
  );

  // Decrypt walks keys Nr..0 (equivalent inverse cipher).
  assign rnd_index   = dir_q ? NR - step : step;
  assign rnd_initial = (step == '0);
  assign rnd_final   = last;
  assign rnd_decrypt = dir_q;
  assign rnd_state   = state_q;
  assign out_state   = state_q;

endmodule

// File: tb/tb_aes_round_controller.sv
// Directed bench for aes_round_controller with a behavioral AES round.
// Two instances: Nr=10 (AES-128) and Nr=14 (AES-256).
module tb_aes_round_controller;
  import AESDefinitions::*;

  localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] KA  =
    256'h2b7e151628aed2a6abf7158809cf4f3c_00000000000000000000000000000000;
  localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT2 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KB  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic         a_in_valid, a_in_ready, a_in_decrypt;
  state_t       a_in_state, a_rnd_state, a_rnd_result, a_out_state;
  logic         a_rnd_valid, a_rnd_initial, a_rnd_final, a_rnd_decrypt;
  round_index_t a_rnd_index;
  logic         a_out_valid, a_out_ready;

  logic         b_in_valid, b_in_ready, b_in_decrypt;
  state_t       b_in_state, b_rnd_state, b_rnd_result, b_out_state;
  logic         b_rnd_valid, b_rnd_initial, b_rnd_final, b_rnd_decrypt;
  round_index_t b_rnd_index;
  logic         b_out_valid, b_out_ready;

  aes_round_controller #(.NUM_ROUNDS(10)) dut_a (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (a_in_valid),
    .in_ready    (a_in_ready),
    .in_decrypt  (a_in_decrypt),
    .in_state    (a_in_state),
    .rnd_valid   (a_rnd_valid),
    .rnd_state   (a_rnd_state),
    .rnd_index   (a_rnd_index),
    .rnd_initial (a_rnd_initial),
    .rnd_final   (a_rnd_final),
    .rnd_decrypt (a_rnd_decrypt),
    .rnd_result  (a_rnd_result),
    .out_valid   (a_out_valid),
    .out_ready   (a_out_ready),
    .out_state   (a_out_state)
  );

  aes_round_controller #(.NUM_ROUNDS(14)) dut_b (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (b_in_valid),
    .in_ready    (b_in_ready),
    .in_decrypt  (b_in_decrypt),
    .in_state    (b_in_state),
    .rnd_valid   (b_rnd_valid),
    .rnd_state   (b_rnd_state),
    .rnd_index   (b_rnd_index),
    .rnd_initial (b_rnd_initial),
    .rnd_final   (b_rnd_final),
    .rnd_decrypt (b_rnd_decrypt),
    .rnd_result  (b_rnd_result),
    .out_valid   (b_out_valid),
    .out_ready   (b_out_ready),
    .out_state   (b_out_state)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]   sb [256];
  logic [7:0]   isb [256];
  logic [127:0] rk_a [16];
  logic [127:0] dk_a [16];
  logic [127:0] rk_b [16];
  logic [127:0] dk_b [16];

  int   idx_log [16];
  logic ini_log [16];
  logic fin_log [16];
  int   nlog;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s,
                                             input logic inv);
    logic [127:0] o;
    int src;
    int dst;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        src = r + 4 * ((c + r) % 4);
        dst = r + 4 * c;
        if (!inv) o[127-8*dst -: 8] = sb[s[127-8*src -: 8]];
        else      o[127-8*src -: 8] = isb[s[127-8*dst -: 8]];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s,
                                       input logic inv);
    logic [127:0] o;
    logic [7:0]   m [4];
    logic [7:0]   acc;
    o = '0;
    if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        acc = '0;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gm(m[(j - i + 4) % 4], s[127-8*(4*c+j) -: 8]);
        o[127-8*(4*c+i) -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s,
                                            input logic [127:0] k,
                                            input logic ini,
                                            input logic fin,
                                            input logic dec);
    logic [127:0] t;
    if (ini) return s ^ k;
    t = sub_shift(s, dec);
    if (!fin) t = mix(t, dec);
    return t ^ k;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [127:0] rkey(input logic [255:0] key,
                                        input int nk, input int j);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 64; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (j + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    return {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endfunction

  always_comb begin
    a_rnd_result = round_fn(a_rnd_state,
      a_rnd_decrypt ? dk_a[a_rnd_index] : rk_a[a_rnd_index],
      a_rnd_initial, a_rnd_final, a_rnd_decrypt);
  end

  always_comb begin
    b_rnd_result = round_fn(b_rnd_state,
      b_rnd_decrypt ? dk_b[b_rnd_index] : rk_b[b_rnd_index],
      b_rnd_initial, b_rnd_final, b_rnd_decrypt);
  end

  task automatic build_model();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
      isb[s] = 8'(x);
    end
    for (int j = 0; j < 16; j++) begin
      rk_a[j] = (j <= 10) ? rkey(KA, 4, j) : '0;
      dk_a[j] = (j > 0 && j < 10) ? mix(rk_a[j], 1'b1) : rk_a[j];
      rk_b[j] = (j <= 14) ? rkey(KB, 8, j) : '0;
      dk_b[j] = (j > 0 && j < 14) ? mix(rk_b[j], 1'b1) : rk_b[j];
    end
  endtask

  // Stimulus only: sends one block on instance A from IDLE, logs rounds.
  task automatic run_a(input logic dec, input logic [127:0] blk,
                       input logic rdy, output int lat,
                       output logic [127:0] res, output logic ok);
    a_in_state   = blk;
    a_in_decrypt = dec;
    a_in_valid   = 1'b1;
    a_out_ready  = rdy;
    ok   = 1'b0;
    lat  = 0;
    nlog = 0;
    for (int i = 0; i < 40 && !a_in_ready; i++) begin
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    a_in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (a_rnd_valid && nlog < 16) begin
        idx_log[nlog] = int'(a_rnd_index);
        ini_log[nlog] = a_rnd_initial;
        fin_log[nlog] = a_rnd_final;
        nlog++;
      end
      if (a_out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock); #1;
      lat++;
    end
    res = a_out_state;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_in_ready: got %b want 1", a_in_ready);
    end
    checks++;
    if (a_out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_out_valid: got %b want 0", a_out_valid);
    end
    checks++;
    if (a_rnd_valid !== 1'b0) begin
      failures++; $display("FAIL rst_rnd_valid: got %b want 0", a_rnd_valid);
    end
    checks++;
    if (a_rnd_index !== 4'd0) begin
      failures++; $display("FAIL rst_rnd_index: got %0d want 0", a_rnd_index);
    end
    checks++;
    if (a_rnd_initial !== 1'b1 || a_rnd_final !== 1'b0
        || a_rnd_decrypt !== 1'b0) begin
      failures++;
      $display("FAIL rst_flags: got ini=%b fin=%b dec=%b want 1 0 0",
               a_rnd_initial, a_rnd_final, a_rnd_decrypt);
    end
    checks++;
    if (a_out_state !== 128'h0) begin
      failures++; $display("FAIL rst_state: got %h want 0", a_out_state);
    end
    reset_n = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_rst: got rdy=%b ov=%b want 1 0",
               a_in_ready, a_out_valid);
    end
  endtask

  task automatic test_encrypt();
    int lat;
    logic [127:0] res;
    logic ok;
    run_a(1'b0, PT, 1'b1, lat, res, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL enc_timeout: got no out_valid want 1");
    end
    checks++;
    if (lat != 11) begin
      failures++; $display("FAIL enc_latency: got %0d want 11", lat);
    end
    checks++;
    if (res !== CT) begin
      failures++; $display("FAIL enc_result: got %h want %h", res, CT);
    end
    @(posedge clock); #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL enc_one_pulse: got ov=%b rdy=%b want 0 1",
               a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_decrypt();
    int lat;
    logic [127:0] res;
    logic ok;
    run_a(1'b1, CT, 1'b1, lat, res, ok);
    checks++;
    if (!ok || lat != 11) begin
      failures++; $display("FAIL dec_latency: got %0d want 11", lat);
    end
    checks++;
    if (res !== PT) begin
      failures++; $display("FAIL dec_result: got %h want %h", res, PT);
    end
    checks++;
    if (nlog != 11) begin
      failures++; $display("FAIL dec_nrounds: got %0d want 11", nlog);
    end
    for (int i = 0; i < 11 && i < nlog; i++) begin
      checks++;
      if (idx_log[i] != 10 - i || ini_log[i] !== (i == 0)
          || fin_log[i] !== (i == 10)) begin
        failures++;
        $display("FAIL dec_seq[%0d]: got idx=%0d ini=%b fin=%b want %0d %b %b",
                 i, idx_log[i], ini_log[i], fin_log[i],
                 10 - i, (i == 0), (i == 10));
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    logic [127:0] res;
    logic [127:0] hold;
    logic ok;
    run_a(1'b0, PT, 1'b0, lat, res, ok);
    checks++;
    if (!ok || res !== CT || a_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_first: got %h rdy=%b want %h 0", res, a_in_ready, CT);
    end
    hold = a_out_state;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_state !== CT
          || a_in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got ov=%b st=%h rdy=%b want 1 %h 0",
                 i, a_out_valid, a_out_state, a_in_ready, hold);
      end
    end
    a_out_ready = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: got ov=%b rdy=%b want 0 1",
               a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int acc2;
    int nres;
    logic [127:0] r1;
    logic [127:0] r2;
    acc2 = -1;
    nres = 0;
    r1 = '0;
    r2 = '0;
    a_in_state   = PT;
    a_in_decrypt = 1'b0;
    a_in_valid   = 1'b1;
    a_out_ready  = 1'b1;
    @(posedge clock); #1;
    a_in_state   = CT;
    a_in_decrypt = 1'b1;
    for (int t = 0; t < 60; t++) begin
      if (a_out_valid) begin
        if (nres == 0) r1 = a_out_state;
        else if (nres == 1) r2 = a_out_state;
        nres++;
      end
      if (a_in_ready && a_in_valid && acc2 < 0) acc2 = t + 1;
      if (nres >= 2) break;
      @(posedge clock); #1;
      if (acc2 >= 0 && t + 1 == acc2) a_in_valid = 1'b0;
    end
    a_in_valid = 1'b0;
    checks++;
    if (acc2 != 13) begin
      failures++; $display("FAIL b2b_period: got %0d want 13", acc2);
    end
    checks++;
    if (nres != 2) begin
      failures++; $display("FAIL b2b_count: got %0d want 2", nres);
    end
    checks++;
    if (r1 !== CT) begin
      failures++; $display("FAIL b2b_first: got %h want %h", r1, CT);
    end
    checks++;
    if (r2 !== PT) begin
      failures++; $display("FAIL b2b_second: got %h want %h", r2, PT);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    logic [127:0] res;
    logic ok;
    seen = 0;
    a_in_state   = PT;
    a_in_decrypt = 1'b0;
    a_in_valid   = 1'b1;
    a_out_ready  = 1'b1;
    @(posedge clock); #1;
    a_in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (a_rnd_valid !== 1'b1 || a_rnd_index !== 4'd5) begin
      failures++;
      $display("FAIL mid_step: got rv=%b idx=%0d want 1 5",
               a_rnd_valid, a_rnd_index);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 1'b1 || a_rnd_valid !== 1'b0
        || a_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_hs: got rdy=%b rv=%b ov=%b want 1 0 0",
               a_in_ready, a_rnd_valid, a_out_valid);
    end
    checks++;
    if (a_rnd_index !== 4'd0 || a_rnd_initial !== 1'b1
        || a_rnd_final !== 1'b0 || a_out_state !== 128'h0) begin
      failures++;
      $display("FAIL mid_rst_regs: got idx=%0d ini=%b fin=%b st=%h",
               a_rnd_index, a_rnd_initial, a_rnd_final, a_out_state);
    end
    @(posedge clock);
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (a_out_valid || !a_in_ready) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL mid_no_out: got %0d busy cycles want 0", seen);
    end
    run_a(1'b1, CT, 1'b1, lat, res, ok);
    checks++;
    if (!ok || lat != 11 || res !== PT) begin
      failures++;
      $display("FAIL mid_recover: got lat=%0d %h want 11 %h", lat, res, PT);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_aes256();
    int lat;
    logic ok;
    lat = 0;
    ok  = 1'b0;
    b_in_state   = PT2;
    b_in_decrypt = 1'b0;
    b_in_valid   = 1'b1;
    b_out_ready  = 1'b1;
    @(posedge clock); #1;
    b_in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (b_out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock); #1;
      lat++;
    end
    checks++;
    if (!ok || lat != 15) begin
      failures++; $display("FAIL aes256_latency: got %0d want 15", lat);
    end
    checks++;
    if (b_out_state !== CT2) begin
      failures++;
      $display("FAIL aes256_result: got %h want %h", b_out_state, CT2);
    end
    @(posedge clock); #1;
    checks++;
    if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL aes256_done: got ov=%b rdy=%b want 0 1",
               b_out_valid, b_in_ready);
    end
  endtask

  initial begin
    a_in_valid = 1'b0; a_in_decrypt = 1'b0; a_in_state = '0;
    a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_decrypt = 1'b0; b_in_state = '0;
    b_out_ready = 1'b0;
    build_model();
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_aes256();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_round_controller.md
# aes_round_controller

Iterative sequencer for the shared single-round AES datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey and their inverses). It accepts one 128-bit block per transaction over a valid/ready handshake and holds the working state in its own register. It drives the combinational round datapath once per cycle with the round index, direction and initial/final flags, then presents the result over an output valid/ready handshake. It sits between the block-level input buffer and the output stage of the processor.

## Interface
- NUM_ROUNDS, default 10, Nr for the key size (legal values: 10, 12, 14).
- clock  in  1  system clock, rising edge.
- reset_n  in  1  one clock; reset is asynchronous and active-low.
- in_valid  in  1  input block present.
- in_ready  out  1  controller can accept a block.
- in_decrypt  in  1  1 = decrypt, 0 = encrypt; sampled with in_state.
- in_state  in  state_t (128)  input block.
- rnd_valid  out  1  datapath enable, same meaning as the stage-level valid.
- rnd_state  out  state_t  working state register to the datapath.
- rnd_index  out  4  round-key index for the key store.
- rnd_initial  out  1  AddRoundKey only (no Sub/Shift/Mix).
- rnd_final  out  1  skip (Inv)MixColumns.
- rnd_decrypt  out  1  select inverse stages.
- rnd_result  in  state_t  combinational datapath output for the current rnd_state.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_state  out  state_t  result block (equals working state register).

## Operation
- FSM states: IDLE, ROUND, DONE. The FSM is one-hot or encoded; the choice is free.
- IDLE:
  - in_ready=1.
  - On in_valid: state_q <= in_state, dir_q <= in_decrypt, step <= 0, go ROUND.
- ROUND:
  - rnd_valid=1.
  - Each cycle: state_q <= rnd_result.
  - If step==NUM_ROUNDS, go DONE. Otherwise step <= step+1.
- DONE:
  - out_valid=1.
  - On out_ready: go IDLE.
  - state_q holds until accepted.
- Derived outputs, all combinational from registers:
  - rnd_initial = (step==0).
  - rnd_final = (step==NUM_ROUNDS).
  - rnd_index = dir_q ? NUM_ROUNDS-step : step.
  - rnd_decrypt = dir_q.
- The decrypt sequence uses the equivalent inverse-cipher ordering: step 0 applies key Nr, and the final step applies key 0.
- step is 4 bits and never exceeds NUM_ROUNDS. Unsigned subtraction cannot underflow.
- The rnd_* outputs other than rnd_valid are don't-care outside ROUND. They are nevertheless driven from registers, never X.
- in_ready is 0 in ROUND and DONE. The controller has no internal queue, so in_valid is simply ignored there.
- out_state holds stable while out_valid=1 and out_ready=0.

## Timing
- Reset values:
  - state IDLE, in_ready=1, out_valid=0, rnd_valid=0.
  - state_q=0, step=0, dir_q=0.
  - rnd_index=0, rnd_initial=1, rnd_final=0, rnd_decrypt=0.
- Acceptance edge E0. Steps 0..Nr execute on edges E1..E(Nr+1). out_valid rises after E(Nr+1), i.e. latency Nr+1 cycles from acceptance (11/13/15).
- DONE with out_ready=1 returns to IDLE on the same edge. The earliest next acceptance is one cycle later, giving a minimum period of Nr+3 cycles per block.
- out_ready held high in advance: out_valid is high for exactly one cycle.
- Reset asserted mid-ROUND or mid-DONE: immediate return to IDLE with reset values. The in-flight block is discarded, and no out_valid pulse occurs after deassertion.
- in_valid and in_decrypt change while in ROUND: no effect on the running block.

## Structure
- The shared package (AESDefinitions) holds state_t (128-bit, 4x4 bytes), round_index_t (logic [3:0]) and the constants NR_128=10, NR_192=12, NR_256=14.
- The FSM state enum is local to the module.
- Natural sub-module: round_step_counter. It is a loadable up-counter with terminal flag (clear, enable, count==limit) and is reusable by the key-expansion sequencer.
- The round datapath stays outside this block so it can be shared and unit-tested at stage level.

## Test plan
- Bench uses a behavioral round model on rnd_result.
- FIPS-197 B encrypt: key 2b7e151628aed2a6abf7158809cf4f3c, in 3243f6a8885a308d313198a2e0370734, out_ready=1 -> out_valid exactly 11 cycles after acceptance, out_state 3925841d02dc09fbdc118597196a0b32.
- Decrypt of 3925841d02dc09fbdc118597196a0b32 with the same key -> 3243f6a8885a308d313198a2e0370734. Also check the rnd_index sequence 10,9,...,0, with rnd_initial only at index 10 and rnd_final only at index 0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_state stable, in_ready=0 throughout; on the release cycle transfer, then in_ready=1 the next cycle.
- Back-to-back: in_valid held high with two blocks and out_ready=1 -> second acceptance exactly 13 cycles after the first (Nr=10); both results correct.
- Reset mid-operation: reset_n low at round step 5 for 2 cycles -> all outputs at reset values immediately; no out_valid afterwards until a new block completes.
- NUM_ROUNDS=14: encrypt of FIPS-197 C.3 (key 000102...1f, in 00112233445566778899aabbccddeeff) -> 8ea2b7ca516745bfeafc49904b496089 after 15 cycles.
